// File: rtl/nnet_argmax_stage.sv
// nnet_argmax_stage
// Reduces each vector of scores from the HLS network's res_V_V stream to a
// single one-beat result {best_score, best_idx}. The lowest index wins among
// equal maxima. The result is held on the output until the downstream side
// accepts it.
//
// Handshake semantics (both streams): a beat transfers on a rising ap_clk
// edge where tvalid and tready are both high. Once m_axis_tvalid is high it
// stays high, with m_axis_tdata stable, until that transfer. The only
// exceptions are clear and reset. s_axis_tready is a registered state decode,
// gated only by clear. It never looks at s_axis_tvalid or m_axis_tready.
module nnet_argmax_stage #(
  parameter int DATA_W = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        clear,
  input  logic [15:0] vec_size,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] vec_count,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]        r_state;
  logic              r_ready;
  logic [DATA_W-1:0] r_best;
  logic [15:0]       r_best_idx;
  logic [15:0]       r_idx;
  logic [15:0]       r_size_lat;
  logic [31:0]       r_vec_count;

  logic [1:0]        w_next_state;
  logic [DATA_W-1:0] w_score;
  logic              w_s_fire;
  logic              w_m_fire;
  logic              w_gt;
  logic [15:0]       w_size_eff;
  logic              w_last_beat;
  logic [15:0]       w_best_ext;
  logic              w_unused_tdata;

  // Only the low DATA_W bits carry the score.
  assign w_score        = s_axis_tdata[DATA_W-1:0];
  assign w_unused_tdata = &{1'b0, s_axis_tdata[31:DATA_W]};

  // A vector length of 0 is treated as a single-beat vector.
  assign w_size_eff  = (vec_size == 16'd0) ? 16'd1 : vec_size;
  // Only meaningful in ACCUM, where r_size_lat >= 2. r_idx tops out at
  // 65534 for a 65535-beat vector, so it never wraps before HOLD.
  assign w_last_beat = (r_idx == (r_size_lat - 16'd1));

  assign s_axis_tready = r_ready && !clear;
  assign w_s_fire      = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = (r_state == ST_HOLD);
  assign m_axis_tlast  = m_axis_tvalid;
  assign w_m_fire      = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? {w_best_ext, r_best_idx} : 32'd0;
  assign vec_count     = r_vec_count;
  assign dbg_state     = r_state;

  // Strictly-greater comparison in the configured number representation.
  generate
    if (SIGNED) begin : g_cmp_signed
      assign w_gt = $signed(w_score) > $signed(r_best);
    end else begin : g_cmp_unsigned
      assign w_gt = w_score > r_best;
    end
  endgenerate

  // Widen the score to the 16-bit result field (sign or zero fill).
  generate
    if (DATA_W < 16) begin : g_ext
      assign w_best_ext = {{(16-DATA_W){SIGNED ? r_best[DATA_W-1] : 1'b0}}, r_best};
    end else begin : g_noext
      assign w_best_ext = r_best[15:0];
    end
  endgenerate

  // Next-state decode. clear overrides everything and returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_s_fire) begin
            w_next_state = (w_size_eff == 16'd1) ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_s_fire && w_last_beat) begin
            w_next_state = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_m_fire) begin
            w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // State register. The input ready is registered from the next state, so it
  // stays low throughout reset and rises on the first clock edge afterwards.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state != ST_HOLD);
    end
  end

  // Running maximum, its index, beat counter and the latched vector length.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_best     <= '0;
      r_best_idx <= 16'd0;
      r_idx      <= 16'd0;
      r_size_lat <= 16'd0;
    end else if (clear) begin
      r_best     <= '0;
      r_best_idx <= 16'd0;
      r_idx      <= 16'd0;
      r_size_lat <= 16'd0;
    end else if (w_s_fire) begin
      if (r_state == ST_IDLE) begin
        // The first beat seeds the maximum. The length is sampled only here,
        // so a mid-vector change of vec_size applies to the next vector.
        r_best     <= w_score;
        r_best_idx <= 16'd0;
        r_idx      <= 16'd1;
        r_size_lat <= w_size_eff;
      end else begin
        if (w_gt) begin
          r_best     <= w_score;
          r_best_idx <= r_idx;
        end
        r_idx <= r_idx + 16'd1;
      end
    end
  end

  // Count delivered results. clear restarts the count.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_vec_count <= 32'd0;
    end else if (clear) begin
      r_vec_count <= 32'd0;
    end else if (w_m_fire) begin
      r_vec_count <= r_vec_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_nnet_argmax_stage.sv
// Self-checking bench for nnet_argmax_stage. Two instances share all inputs:
// one compares scores as signed, the other as unsigned. Expected results are
// queued when a vector is driven and popped when the output handshakes.
module tb_nnet_argmax_stage;

  // ---------------- clock / reset ----------------
  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        clear    = 1'b0;
  logic [15:0] vec_size = 16'd0;
  logic [31:0] s_tdata  = 32'd0;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b0;

  always #5 clk = ~clk;

  logic        s_sready, s_mlast, s_mvalid;
  logic [31:0] s_mdata, s_vcnt;
  logic [1:0]  s_dbg;
  logic        u_sready, u_mlast, u_mvalid;
  logic [31:0] u_mdata, u_vcnt;
  logic [1:0]  u_dbg;

  nnet_argmax_stage #(.DATA_W(16), .SIGNED(1'b1)) dut_s (
    .ap_clk(clk), .ap_rst_n(rst_n), .clear(clear), .vec_size(vec_size),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_sready),
    .m_axis_tdata(s_mdata), .m_axis_tlast(s_mlast), .m_axis_tvalid(s_mvalid),
    .m_axis_tready(m_tready), .vec_count(s_vcnt), .dbg_state(s_dbg)
  );

  nnet_argmax_stage #(.DATA_W(16), .SIGNED(1'b0)) dut_u (
    .ap_clk(clk), .ap_rst_n(rst_n), .clear(clear), .vec_size(vec_size),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(u_sready),
    .m_axis_tdata(u_mdata), .m_axis_tlast(u_mlast), .m_axis_tvalid(u_mvalid),
    .m_axis_tready(m_tready), .vec_count(u_vcnt), .dbg_state(u_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_u_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare each result as it is presented while the downstream side is ready.
  always @(negedge clk) begin
    if (rst_n && s_mvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h required=none", s_mdata);
      end else begin
        check32("result_signed", s_mdata, exp_q.pop_front());
        check32("result_unsigned", u_mdata, exp_u_q.pop_front());
        check32("tlast", {31'd0, s_mlast}, 32'd1);
        check32("unsigned_valid", {31'd0, u_mvalid}, 32'd1);
        exp_cnt++;
      end
    end
  end

  // Reference argmax over the low 16 bits of each word.
  function automatic logic [31:0] argmax(input int n, input logic [31:0] d[5], input bit sgn);
    logic [15:0] best;
    logic [15:0] bi;
    logic [15:0] s;
    logic        gt;
    best = d[0][15:0];
    bi   = 16'd0;
    for (int i = 1; i < n; i++) begin
      s  = d[i][15:0];
      gt = sgn ? ($signed(s) > $signed(best)) : (s > best);
      if (gt) begin
        best = s;
        bi   = 16'(i);
      end
    end
    return {best, bi};
  endfunction

  // ---------------- driver tasks ----------------
  // Present one beat; returns once the beat will be taken on the next edge.
  task automatic send_beat(input logic [15:0] sz, input logic [31:0] d);
    bit ok;
    int guard;
    ok    = 1'b0;
    guard = 0;
    while (!ok) begin
      @(posedge clk);
      #1;
      vec_size = sz;
      s_tdata  = d;
      s_tvalid = 1'b1;
      #1;
      ok = s_sready;
      guard++;
      if (!ok && guard > 200) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout actual=ready_low required=ready_high");
        ok = 1'b1;
      end
    end
  endtask

  // sz applies to the first beat, sz2 to the rest (to move vec_size mid-vector).
  task automatic drive_vec(input logic [15:0] sz, input logic [15:0] sz2, input int n,
                           input logic [31:0] d[5]);
    for (int i = 0; i < n; i++) begin
      send_beat((i == 0) ? sz : sz2, d[i]);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] es, input logic [31:0] eu);
    exp_q.push_back(es);
    exp_u_q.push_back(eu);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
  endtask

  task automatic wait_mvalid();
    int g;
    g = 0;
    while (!s_mvalid && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (!s_mvalid) begin
      failures++;
      $display("FAIL mvalid_timeout actual=0 required=1");
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] sz;
    int          n;
    logic [31:0] d[5];
    logic [31:0] es;
    logic [31:0] eu;
  } vec_t;

  vec_t vt[8];

  task automatic set_vec(input int k, input logic [15:0] sz, input int n,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] e, input logic [31:0] f,
                         input logic [31:0] es, input logic [31:0] eu);
    vt[k].sz   = sz;
    vt[k].n    = n;
    vt[k].d[0] = a;
    vt[k].d[1] = b;
    vt[k].d[2] = c;
    vt[k].d[3] = e;
    vt[k].d[4] = f;
    vt[k].es   = es;
    vt[k].eu   = eu;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] dd[5];
    int          n;

    set_vec(0, 16'd5, 5, 32'h3, 32'hFFFE, 32'h7, 32'h7, 32'h1, 32'h0007_0002, 32'hFFFE_0001);
    set_vec(1, 16'd4, 4, 32'hFFF0, 32'hFFFE, 32'h8000, 32'hFFFD, 32'h0, 32'hFFFE_0001, 32'hFFFE_0001);
    set_vec(2, 16'd2, 2, 32'h8000, 32'h0001, 32'h0, 32'h0, 32'h0, 32'h0001_0001, 32'h8000_0000);
    set_vec(3, 16'd0, 1, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_0000, 32'h1234_0000);
    set_vec(4, 16'd1, 1, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_0000, 32'h1234_0000);
    set_vec(5, 16'd3, 3, 32'h5, 32'h5, 32'h5, 32'h0, 32'h0, 32'h0005_0000, 32'h0005_0000);
    set_vec(6, 16'd3, 3, 32'hFFFF_0001, 32'h0000_0002, 32'h7FFF_0000, 32'h0, 32'h0,
            32'h0002_0001, 32'h0002_0001);
    set_vec(7, 16'd4, 4, 32'h7FFF, 32'h8000, 32'h0, 32'hFFFF, 32'h0, 32'h7FFF_0000, 32'hFFFF_0003);

    // Reset state
    #3;
    check32("rst_s_tready", {31'd0, s_sready}, 32'd0);
    check32("rst_m_tvalid", {31'd0, s_mvalid}, 32'd0);
    check32("rst_m_tlast", {31'd0, s_mlast}, 32'd0);
    check32("rst_m_tdata", s_mdata, 32'd0);
    check32("rst_vec_count", s_vcnt, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check32("idle_s_tready", {31'd0, s_sready}, 32'd1);
    check32("idle_state", {30'd0, s_dbg}, 32'd0);

    // Table-driven vectors, downstream always ready
    m_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push_exp(vt[k].es, vt[k].eu);
      drive_vec(vt[k].sz, vt[k].sz, vt[k].n, vt[k].d);
    end
    drain();
    check32("vec_count_table", s_vcnt, 32'd8);
    check32("vec_count_model", s_vcnt, 32'(exp_cnt));

    // vec_size changed 4->2 after the first beat: the vector still spans 4 beats
    dd = '{32'h1, 32'h9, 32'h2, 32'h3, 32'h0};
    push_exp(32'h0009_0001, 32'h0009_0001);
    drive_vec(16'd4, 16'd2, 4, dd);
    dd = '{32'h4, 32'h6, 32'h0, 32'h0, 32'h0};
    push_exp(32'h0006_0001, 32'h0006_0001);
    drive_vec(16'd2, 16'd2, 2, dd);
    drain();
    check32("vec_count_sizechg", s_vcnt, 32'd10);

    // Backpressure: result held for 10 cycles, input stalled
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    dd = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h0};
    push_exp(32'h0003_0002, 32'h0003_0002);
    drive_vec(16'd3, 16'd3, 3, dd);
    check32("latency_m_tvalid", {31'd0, s_mvalid}, 32'd1);
    wait_mvalid();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check32("bp_s_tready", {31'd0, s_sready}, 32'd0);
      check32("bp_m_tdata", s_mdata, 32'h0003_0002);
      check32("bp_m_tvalid", {31'd0, s_mvalid}, 32'd1);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    dd = '{32'h8, 32'h3, 32'h8, 32'h0, 32'h0};
    push_exp(32'h0008_0000, 32'h0008_0000);
    drive_vec(16'd3, 16'd3, 3, dd);
    drain();
    check32("vec_count_bp", s_vcnt, 32'd12);

    // clear after 2 of 4 beats discards the partial vector
    send_beat(16'd4, 32'h7000);
    send_beat(16'd4, 32'h7001);
    @(posedge clk);
    #1;
    clear    = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'h7FFF;
    #1;
    check32("clear_s_tready", {31'd0, s_sready}, 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    s_tvalid = 1'b0;
    exp_cnt  = 0;
    check32("clear_vec_count", s_vcnt, 32'd0);
    check32("clear_m_tvalid", {31'd0, s_mvalid}, 32'd0);
    check32("clear_state", {30'd0, s_dbg}, 32'd0);
    dd = '{32'h2, 32'hA, 32'h3, 32'h1, 32'h0};
    push_exp(32'h000A_0001, 32'h000A_0001);
    drive_vec(16'd4, 16'd4, 4, dd);
    drain();
    check32("vec_count_after_clear", s_vcnt, 32'd1);

    // Random vectors checked against the reference model
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < 5; i++) dd[i] = $urandom;
      push_exp(argmax(n, dd, 1'b1), argmax(n, dd, 1'b0));
      drive_vec(16'(n), 16'(n), n, dd);
    end
    drain();
    check32("vec_count_random", s_vcnt, 32'(exp_cnt));

    // Asynchronous reset while a result is held
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    dd = '{32'h55, 32'h0, 32'h0, 32'h0, 32'h0};
    drive_vec(16'd1, 16'd1, 1, dd);
    wait_mvalid();
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check32("arst_m_tvalid", {31'd0, s_mvalid}, 32'd0);
    check32("arst_m_tdata", s_mdata, 32'd0);
    check32("arst_m_tlast", {31'd0, s_mlast}, 32'd0);
    check32("arst_vec_count", s_vcnt, 32'd0);
    check32("arst_s_tready", {31'd0, s_sready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check32("post_rst_s_tready", {31'd0, s_sready}, 32'd1);
    m_tready = 1'b1;
    dd = '{32'h10, 32'h20, 32'h0, 32'h0, 32'h0};
    push_exp(32'h0020_0001, 32'h0020_0001);
    drive_vec(16'd2, 16'd2, 2, dd);
    drain();
    check32("vec_count_post_rst", s_vcnt, 32'd1);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nnet_argmax_stage.md
# nnet_argmax_stage

Classification back-end for the neural-net datapath: consumes the HLS network's score stream (one 16-bit score per beat, no tlast, vector length given by the network's `const_size_out`) and reduces each vector to a single word carrying the winning class index and its score. It sits directly downstream of the HLS block's `res_V_V` port and upstream of the vector wrapper's return path. Each output word is a one-beat packet (tlast=1).

## Interface
- `DATA_W`, 16, score width taken from `s_axis_tdata[DATA_W-1:0]`
- `SIGNED`, 1, 1 = scores compared as two's complement, 0 = unsigned
- `ap_clk`  in  1  block clock (compute-engine clock)
- `ap_rst_n`  in  1  reset, asynchronous and active-low
- `clear`  in  1  synchronous flush, driven from `clear_tx_seqnum`
- `vec_size`  in  16  scores per vector (`const_size_out`); 0 treated as 1
- `s_axis_tdata`  in  32  score in `[DATA_W-1:0]`; upper bits ignored
- `s_axis_tvalid`  in  1  score valid (HLS `res_V_V_TVALID`)
- `s_axis_tready`  out  1  score accepted (HLS `res_V_V_TREADY`)
- `m_axis_tdata`  out  32  `{best_score[15:0], best_idx[15:0]}`; score sign-extended/zero-padded to 16 bits when `DATA_W<16`
- `m_axis_tlast`  out  1  equals `m_axis_tvalid`
- `m_axis_tvalid`  out  1  result valid
- `m_axis_tready`  in  1  downstream ready
- `vec_count`  out  32  completed vectors delivered (wraps at 2^32)

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE: `s_axis_tready=1`. On first accepted beat: `best<=score`, `best_idx<=0`, `idx<=1`, latch `size_lat<=(vec_size==0)?1:vec_size`. If `size_lat==1` go HOLD, else ACCUM.
- ACCUM: `s_axis_tready=1`. On each accepted beat: if `score > best` (strictly, per `SIGNED`) then `best<=score`, `best_idx<=idx`; `idx<=idx+1`. When the accepted beat has `idx==size_lat-1`, go HOLD (comparison for that beat is still applied).
- HOLD: `s_axis_tready=0`, `m_axis_tvalid=1`, `m_axis_tdata` stable. On `m_axis_tvalid && m_axis_tready`: `vec_count<=vec_count+1`, go IDLE.
- Ties: strictly-greater rule, so the lowest index among equal maxima wins.
- `vec_size` is sampled only on the first beat of a vector; changes mid-vector take effect on the next vector.
- `s_axis_tdata` upper bits never affect the result.
- `clear` (any state): next cycle state=IDLE, `idx=0`, `best=0`, `best_idx=0`, `m_axis_tvalid=0`, `vec_count=0`. A partial vector or held result is discarded. A beat presented in the `clear` cycle is not accepted (`s_axis_tready=0` while `clear=1`).
- Reset (`ap_rst_n=0`, async): state=IDLE, all registers 0. Outputs during and after reset: `s_axis_tready=0` while in reset, then 1 in IDLE; `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `vec_count=0`.

## Timing
- Input throughput: 1 score/cycle in IDLE/ACCUM; no bubbles inside a vector.
- Latency: `m_axis_tvalid` asserts the cycle after the last score of a vector is accepted.
- `s_axis_tready` is a registered state decode only. It does not depend combinationally on `s_axis_tvalid` or `m_axis_tready`.
- Per-vector cost: N input cycles + ≥1 HOLD cycle. Back-to-back vectors with `m_axis_tready=1` give N+1 cycles per vector.
- AXI-Stream rules on the output: once asserted, `m_axis_tvalid` and `m_axis_tdata` hold until the handshake, except when `clear` or reset is asserted.
- `idx` is 16 bits, and the maximum vector length is 65535. `vec_size=65535` must not wrap `idx` before HOLD.

## Test plan
- Signed argmax: `vec_size=5`, scores 3, −2, 7, 7, 1, `m_axis_tready=1` → one beat `m_axis_tdata=0x0007_0002`, tlast=1, `vec_count=1`.
- All negative, `SIGNED=1`: `vec_size=4`, scores 0xFFF0, 0xFFFE, 0x8000, 0xFFFD → `0xFFFE_0001`. The same stimulus with `SIGNED=0` → `0xFFFE_0001`; with scores 0x8000, 0x0001 (`vec_size=2`) → `0x8000_0000`.
- Backpressure: `vec_size=3`, hold `m_axis_tready=0` for 10 cycles after the result → `s_axis_tready=0` and tdata stable throughout. Then assert `m_axis_tready` → handshake and return to IDLE; the next vector of 3 beats is accepted.
- Size edge cases: `vec_size=0` and `vec_size=1` with score 0x1234 → every beat yields its own result `0x1234_0000`. Change `vec_size` 4→2 mid-vector → the current vector still ends after 4 beats.
- Clear/reset: `clear` after 2 of 4 beats, then send a new 4-beat vector → exactly one result, computed only from the new beats; `vec_count` goes 0→1. Assert `ap_rst_n=0` asynchronously in HOLD → `m_axis_tvalid` drops immediately and all outputs read 0.
